// File: rtl/vga_plot_pkg.sv
// -----------------------------------------------------------------------------
// vga_plot_pkg
// Shared types and constants for the VGA effect plotter.
//   plotState_t  - sequencer FSM state encoding
//   octant_t     - 3-bit needle direction (0 = up, counting clockwise)
//   needleGeom_t - per-octant step direction and needle length
//   COLOUR_*     - RGB444 colours used for boxes, needles and background
//   needleGeom() - octant -> (x step, y step, length) lookup
// -----------------------------------------------------------------------------
package vga_plot_pkg;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_CLEAR      = 3'd1,
        S_BOX        = 3'd2,
        S_KNOB_START = 3'd3,
        S_ERASE      = 3'd4,
        S_LINE       = 3'd5,
        S_DONE       = 3'd6
    } plotState_t;

    typedef logic [2:0] octant_t;

    // Direction is kept as separate +/- flags so the pixel arithmetic never
    // has to sign-extend a tiny signed field.
    typedef struct packed {
        logic       xPos;
        logic       xNeg;
        logic       yPos;
        logic       yNeg;
        logic [7:0] len;
    } needleGeom_t;

    localparam logic [11:0] COLOUR_ON   = 12'h2c3;
    localparam logic [11:0] COLOUR_OFF  = 12'h222;
    localparam logic [11:0] COLOUR_LINE = 12'hc38;
    localparam logic [11:0] COLOUR_BG   = 12'h000;

    // Diagonal needles are one pixel shorter so they look about as long as
    // the orthogonal ones on screen.
    function automatic needleGeom_t needleGeom(input octant_t oct, input int knobLen);
        needleGeom_t g;
        g = '0;
        case (oct)
            3'd0: g.yNeg = 1'b1;
            3'd1: begin g.xPos = 1'b1; g.yNeg = 1'b1; end
            3'd2: g.xPos = 1'b1;
            3'd3: begin g.xPos = 1'b1; g.yPos = 1'b1; end
            3'd4: g.yPos = 1'b1;
            3'd5: begin g.xNeg = 1'b1; g.yPos = 1'b1; end
            3'd6: g.xNeg = 1'b1;
            default: begin g.xNeg = 1'b1; g.yNeg = 1'b1; end
        endcase
        g.len = oct[0] ? 8'(knobLen - 1) : 8'(knobLen);
        return g;
    endfunction

endpackage

// File: rtl/knob_octant_decode.sv
// -----------------------------------------------------------------------------
// knob_octant_decode
// Combinational control-value decode for the VGA effect plotter.
//   knobValue  in  DATA_W  unsigned control value
//   octant     out 3       needle octant for knobValue
//   lookupOct  in  3       octant whose needle geometry is wanted
//   geom       out         direction flags and pixel count for lookupOct
// The two halves are independent: the sequencer decodes the new value while
// it may still be drawing (erasing) a previously stored octant.
// -----------------------------------------------------------------------------
module knob_octant_decode
    import vga_plot_pkg::*;
#(
    parameter int DATA_W   = 7,
    parameter int KNOB_LEN = 8
) (
    input  logic [DATA_W-1:0] knobValue,
    output octant_t           octant,
    input  octant_t           lookupOct,
    output needleGeom_t       geom
);

    // The value sweep wraps around at the top: both very small and very large
    // values point straight up.
    always_comb begin
        int d;
        d = int'(knobValue);
        if (d <= 8 || d >= 92) octant = 3'd0;
        else if (d < 19)       octant = 3'd1;
        else if (d < 31)       octant = 3'd2;
        else if (d < 43)       octant = 3'd3;
        else if (d < 55)       octant = 3'd4;
        else if (d < 67)       octant = 3'd5;
        else if (d < 79)       octant = 3'd6;
        else                   octant = 3'd7;
    end

    always_comb begin
        geom = needleGeom(lookupOct, KNOB_LEN);
    end

endmodule

// File: rtl/vga_effect_plotter.sv
// -----------------------------------------------------------------------------
// vga_effect_plotter
// Pixel-draw sequencer feeding a VGA adapter write port. Per channel it draws
// an on/off status box and a pointer needle (erasing the old needle first),
// and it clears the whole screen after reset or on request.
//   Clock, Reset  system clock, asynchronous active-high reset
//   clear_req     pulse: queue a full-screen clear
//   box_on_req    per-channel pulse: draw box in COLOUR_ON (wins over off)
//   box_off_req   per-channel pulse: draw box in COLOUR_OFF
//   knob_req      per-channel pulse: redraw needle from knob_data
//   knob_data     packed control values, channel 0 in the LSBs
//   busy          a job is executing or pending
//   done          one-cycle pulse at the end of each job
//   colour, x, y  pixel colour and coordinates, valid with writeEn
//   writeEn       pixel write strobe (one pixel per cycle)
//   stateDbg      current sequencer state
// Optional build macro VGA_PLOT_REDRAW_EN: after a clear, re-queue every box
// (in its last requested colour) and every needle that has ever been set.
//
// Handshake: requests are single-cycle pulses latched into sticky pending
// bits; there is no back-pressure. Priority is clear > box > needle, with one
// round-robin pointer shared by the box and needle classes.
// -----------------------------------------------------------------------------
module vga_effect_plotter
    import vga_plot_pkg::*;
#(
    parameter int NUM_CH   = 3,
    parameter int DATA_W   = 7,
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120,
    parameter int BOX_X0   = 26,
    parameter int BOX_Y0   = 21,
    parameter int BOX_W    = 17,
    parameter int BOX_H    = 7,
    parameter int CH_PITCH = 47,
    parameter int KNOB_CX0 = 33,
    parameter int KNOB_CY  = 52,
    parameter int KNOB_LEN = 8
) (
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic                     clear_req,
    input  logic [NUM_CH-1:0]        box_on_req,
    input  logic [NUM_CH-1:0]        box_off_req,
    input  logic [NUM_CH-1:0]        knob_req,
    input  logic [NUM_CH*DATA_W-1:0] knob_data,
    output logic                     busy,
    output logic                     done,
    output logic [11:0]              colour,
    output logic [7:0]               x,
    output logic [6:0]               y,
    output logic                     writeEn,
    output plotState_t               stateDbg
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    localparam logic [7:0] CLR_LAST_X = 8'(SCREEN_W - 1);
    localparam logic [6:0] CLR_LAST_Y = 7'(SCREEN_H - 1);
    localparam logic [7:0] BOX_LAST_I = 8'(BOX_W - 1);
    localparam logic [6:0] BOX_LAST_J = 7'(BOX_H - 1);

    plotState_t state, stateNext;

    logic              clearPend, clearPendNext;
    logic [NUM_CH-1:0] boxPend, boxPendNext;
    logic [NUM_CH-1:0] boxOn, boxOnNext;     // last requested on/off per channel
    logic [NUM_CH-1:0] knobPend, knobPendNext;
    logic [CH_W-1:0]   rrPtr;
    logic [CH_W-1:0]   chSel;
    logic              boxColourOn;
    octant_t           newOct;
    octant_t           octStore [NUM_CH];
    logic [NUM_CH-1:0] lastValid;
    logic [7:0]        cntI;
    logic [6:0]        cntJ;

`ifdef VGA_PLOT_REDRAW_EN
    logic [NUM_CH-1:0] knobSeen;
`endif

    logic              boxFound, knobFound;
    logic [CH_W-1:0]   boxGntCh, knobGntCh;
    logic              grantClear, grantBox, grantKnob;
    logic [NUM_CH-1:0] boxMask, knobMask;
    logic              lastPixel;
    logic              busyNext;

    logic [DATA_W-1:0] knobVals [NUM_CH];
    octant_t           decOct;
    octant_t           drawOct;
    needleGeom_t       geom;

    logic              wrNext, doneNext;
    logic [11:0]       colourNext;
    logic [7:0]        xNext;
    logic [6:0]        yNext;

    // Returns {found, channel}: first set bit at or after start, wrapping.
    function automatic logic [CH_W:0] rrPick(input logic [NUM_CH-1:0] pend,
                                             input logic [CH_W-1:0]   start);
        logic [CH_W:0] r;
        int            idx;
        r = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            idx = int'(start) + k;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            if (pend[CH_W'(idx)]) r = {1'b1, CH_W'(idx)};
        end
        return r;
    endfunction

    function automatic logic [CH_W-1:0] rrAfter(input logic [CH_W-1:0] ch);
        return (ch == CH_W'(NUM_CH - 1)) ? '0 : ch + CH_W'(1);
    endfunction

    // ---------------- needle decode ----------------
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            knobVals[c] = knob_data[c*DATA_W +: DATA_W];
        end
    end

    // While erasing, the geometry must come from the old octant.
    assign drawOct = (state == S_ERASE) ? octStore[chSel] : newOct;

    knob_octant_decode #(
        .DATA_W   (DATA_W),
        .KNOB_LEN (KNOB_LEN)
    ) u_decode (
        .knobValue (knobVals[chSel]),
        .octant    (decOct),
        .lookupOct (drawOct),
        .geom      (geom)
    );

    // ---------------- arbitration ----------------
    always_comb begin
        {boxFound, boxGntCh}   = rrPick(boxPend, rrPtr);
        {knobFound, knobGntCh} = rrPick(knobPend, rrPtr);
        grantClear = (state == S_IDLE) && clearPend;
        grantBox   = (state == S_IDLE) && !clearPend && boxFound;
        grantKnob  = (state == S_IDLE) && !clearPend && !boxFound && knobFound;
        boxMask    = grantBox  ? (NUM_CH'(1) << boxGntCh)  : '0;
        knobMask   = grantKnob ? (NUM_CH'(1) << knobGntCh) : '0;
    end

    always_comb begin
        case (state)
            S_CLEAR:         lastPixel = (cntI == CLR_LAST_X) && (cntJ == CLR_LAST_Y);
            S_BOX:           lastPixel = (cntI == BOX_LAST_I) && (cntJ == BOX_LAST_J);
            S_ERASE, S_LINE: lastPixel = (cntI == geom.len - 8'd1);
            default:         lastPixel = 1'b0;
        endcase
    end

    // Pending bits: a request arriving in the grant cycle survives the clear,
    // so a channel re-requested while in service is served again afterwards.
    always_comb begin
        clearPendNext = (clearPend & ~grantClear) | clear_req;
        boxPendNext   = (boxPend & ~boxMask) | box_on_req | box_off_req;
        boxOnNext     = box_on_req | (boxOn & ~box_off_req);
        knobPendNext  = (knobPend & ~knobMask) | knob_req;
`ifdef VGA_PLOT_REDRAW_EN
        if (state == S_CLEAR && lastPixel) begin
            boxPendNext  = '1;
            knobPendNext = knobPendNext | knobSeen | knob_req;
        end
`endif
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) state <= S_IDLE;
        else       state <= stateNext;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        stateNext = state;
        case (state)
            S_IDLE: begin
                if (grantClear)     stateNext = S_CLEAR;
                else if (grantBox)  stateNext = S_BOX;
                else if (grantKnob) stateNext = S_KNOB_START;
            end
            S_CLEAR: if (lastPixel) stateNext = S_DONE;
            S_BOX:   if (lastPixel) stateNext = S_DONE;
            S_KNOB_START: begin
                if (lastValid[chSel] && (decOct == octStore[chSel])) stateNext = S_DONE;
                else if (lastValid[chSel])                          stateNext = S_ERASE;
                else                                                stateNext = S_LINE;
            end
            S_ERASE: if (lastPixel) stateNext = S_LINE;
            S_LINE:  if (lastPixel) stateNext = S_DONE;
            S_DONE:  stateNext = S_IDLE;
            default: stateNext = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs (next values of the output registers) ----
    always_comb begin
        int cx;
        wrNext     = 1'b0;
        doneNext   = (state == S_DONE);
        colourNext = colour;
        xNext      = x;
        yNext      = y;
        cx         = KNOB_CX0 + int'(chSel) * CH_PITCH;
        case (state)
            S_CLEAR: begin
                wrNext     = 1'b1;
                colourNext = COLOUR_BG;
                xNext      = cntI;
                yNext      = cntJ;
            end
            S_BOX: begin
                wrNext     = 1'b1;
                colourNext = boxColourOn ? COLOUR_ON : COLOUR_OFF;
                xNext      = 8'(BOX_X0 + int'(chSel) * CH_PITCH + int'(cntI));
                yNext      = 7'(BOX_Y0 + int'(cntJ));
            end
            S_ERASE, S_LINE: begin
                wrNext     = 1'b1;
                colourNext = (state == S_ERASE) ? COLOUR_BG : COLOUR_LINE;
                xNext      = 8'(cx + (geom.xPos ? int'(cntI) : 0)
                                   - (geom.xNeg ? int'(cntI) : 0));
                yNext      = 7'(KNOB_CY + (geom.yPos ? int'(cntI) : 0)
                                        - (geom.yNeg ? int'(cntI) : 0));
            end
            default: ;
        endcase
        busyNext = (stateNext != S_IDLE) || clearPendNext
                   || (|boxPendNext) || (|knobPendNext);
    end

    // ---------------- datapath and output registers ----------------
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            writeEn     <= 1'b0;
            done        <= 1'b0;
            busy        <= 1'b1;
            colour      <= '0;
            x           <= '0;
            y           <= '0;
            clearPend   <= 1'b1;
            boxPend     <= '0;
            boxOn       <= '0;
            knobPend    <= '0;
            rrPtr       <= '0;
            chSel       <= '0;
            boxColourOn <= 1'b0;
            newOct      <= '0;
            lastValid   <= '0;
            cntI        <= '0;
            cntJ        <= '0;
            for (int c = 0; c < NUM_CH; c++) octStore[c] <= '0;
`ifdef VGA_PLOT_REDRAW_EN
            knobSeen    <= '0;
`endif
        end else begin
            writeEn   <= wrNext;
            done      <= doneNext;
            busy      <= busyNext;
            colour    <= colourNext;
            x         <= xNext;
            y         <= yNext;
            clearPend <= clearPendNext;
            boxPend   <= boxPendNext;
            boxOn     <= boxOnNext;
            knobPend  <= knobPendNext;
`ifdef VGA_PLOT_REDRAW_EN
            knobSeen  <= knobSeen | knob_req;
`endif

            if (grantBox) begin
                chSel       <= boxGntCh;
                boxColourOn <= boxOn[boxGntCh];
                rrPtr       <= rrAfter(boxGntCh);
            end else if (grantKnob) begin
                chSel <= knobGntCh;
                rrPtr <= rrAfter(knobGntCh);
            end

            case (state)
                S_CLEAR: begin
                    if (cntI == CLR_LAST_X) begin
                        cntI <= '0;
                        cntJ <= cntJ + 7'd1;
                    end else begin
                        cntI <= cntI + 8'd1;
                    end
                    if (lastPixel) lastValid <= '0;
                end
                S_BOX: begin
                    if (cntI == BOX_LAST_I) begin
                        cntI <= '0;
                        cntJ <= cntJ + 7'd1;
                    end else begin
                        cntI <= cntI + 8'd1;
                    end
                end
                S_KNOB_START: begin
                    newOct <= decOct;
                    cntI   <= '0;
                    cntJ   <= '0;
                end
                S_ERASE: begin
                    cntI <= lastPixel ? 8'd0 : cntI + 8'd1;
                end
                S_LINE: begin
                    cntI <= lastPixel ? 8'd0 : cntI + 8'd1;
                    if (lastPixel) begin
                        octStore[chSel]  <= newOct;
                        lastValid[chSel] <= 1'b1;
                    end
                end
                default: begin
                    cntI <= '0;
                    cntJ <= '0;
                end
            endcase
        end
    end

    assign stateDbg = state;

endmodule
